icache: RTL and testbench

Direct-mapped instruction cache between the instruction fetcher and the memory controller. It serves 32-bit instruction words to the fetcher, and on a miss refills a 4-word line. The refill uses four sequential word reads over the memory controller's fetcher port (enable/start/end). The memory controller gives LSU traffic priority, so a refill's word latency is variable and the cache never assumes a fixed memory latency.

---
 rtl/icache_pkg.sv | 20 ++
 rtl/icache_array.sv | 59 +++++
 rtl/icache.sv | 178 +++++++++++++++++
 tb/tb_icache.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared constants and state encoding for the instruction cache
//
// Purpose: widths, line geometry, FSM state enum and boolean constants used by
// icache and icache_array.
package icache_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int INST_WIDTH = 32;
    localparam int LINE_WORDS = 4;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } icache_state_e;

endpackage

// File: rtl/icache_array.sv
// rtl/icache_array.sv - tag, valid and data storage for the direct-mapped instruction cache
//
// Purpose: one line per index holding LINE_WORDS instruction words, a tag and a
// valid bit. Combinational read, synchronous write; only the valid vector is reset.
// Ports:
//   clk, rst            clock, asynchronous active-high clear of the valid vector
//   rd_index, rd_word   read address; rd_data/rd_tag/rd_valid are combinational
//   data_we, wr_index, wr_word, wr_data   single word write into a line
//   tag_we, wr_tag      writes tag of wr_index and marks the line valid
import icache_pkg::*;

module icache_array #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 22
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_index,
    input  logic [1:0]            rd_word,
    output logic [INST_WIDTH-1:0] rd_data,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic                  rd_valid,
    input  logic                  data_we,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [1:0]            wr_word,
    input  logic [INST_WIDTH-1:0] wr_data,
    input  logic                  tag_we,
    input  logic [TAG_BITS-1:0]   wr_tag
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [INST_WIDTH-1:0] data_mem [LINES*LINE_WORDS];
    logic [TAG_BITS-1:0]   tag_mem  [LINES];
    logic [LINES-1:0]      valid;

    // Tag and data are deliberately left unreset; valid gates their use.
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_mem[{wr_index, wr_word}] <= wr_data;
        end
        if (tag_we) begin
            tag_mem[wr_index] <= wr_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (tag_we) begin
            valid[wr_index] <= TRUE;
        end
    end

    assign rd_data  = data_mem[{rd_index, rd_word}];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_valid = valid[rd_index];

endmodule

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped instruction cache with 4-word line refill
//
// Purpose: serves 32-bit words to the fetcher in one cycle on a hit; on a miss
// refills the line with four sequential word reads of variable latency.
// Ports:
//   clk_in, rst_in, rdy_in          clock, async active-high reset, global stall
//   fetch_valid_in, fetch_pc_in     fetch request
//   clear_in                        branch flush
//   ready_out                       request can be accepted this cycle
//   inst_valid_out, inst_out        one-cycle response pulse and word
//   mem_enable_out, mem_addr_out, mem_start_out   word read request to memory
//   mem_end_in, mem_inst_in         word read completion and data
import icache_pkg::*;

module icache #(
    parameter int INDEX_BITS = 6
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  fetch_valid_in,
    input  logic [ADDR_WIDTH-1:0] fetch_pc_in,
    input  logic                  clear_in,
    output logic                  ready_out,
    output logic                  inst_valid_out,
    output logic [INST_WIDTH-1:0] inst_out,
    output logic                  mem_enable_out,
    output logic [ADDR_WIDTH-1:0] mem_addr_out,
    output logic                  mem_start_out,
    input  logic                  mem_end_in,
    input  logic [INST_WIDTH-1:0] mem_inst_in
);

    localparam int TAG_BITS = ADDR_WIDTH - 4 - INDEX_BITS;

    icache_state_e         state, state_n;
    logic [1:0]            cnt, cnt_n;
    logic                  kill, kill_n;
    logic [ADDR_WIDTH-1:2] pc_q, pc_n;
    logic [INST_WIDTH-1:0] line_buf, line_buf_n;

    logic                  ready_n, inst_valid_n, mem_enable_n, mem_start_n;
    logic [INST_WIDTH-1:0] inst_n;
    logic [ADDR_WIDTH-1:0] mem_addr_n;

    logic [INST_WIDTH-1:0] rd_data;
    logic [TAG_BITS-1:0]   rd_tag;
    logic                  rd_valid;
    logic                  accept, hit, data_we, tag_we;
    logic [1:0]            unused_pc_bits;

    assign unused_pc_bits = fetch_pc_in[1:0];

    // Lookup always uses the incoming pc; it only matters in IDLE.
    assign accept = fetch_valid_in && ready_out && !clear_in;
    assign hit    = rd_valid && (rd_tag == fetch_pc_in[ADDR_WIDTH-1:4+INDEX_BITS]);

    // Refill writes are gated by rdy_in so a stalled cycle never commits data.
    assign data_we = rdy_in && (state == WAIT) && mem_end_in;
    assign tag_we  = data_we && (cnt == 2'd3);

    icache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .clk      (clk_in),
        .rst      (rst_in),
        .rd_index (fetch_pc_in[3+INDEX_BITS:4]),
        .rd_word  (fetch_pc_in[3:2]),
        .rd_data  (rd_data),
        .rd_tag   (rd_tag),
        .rd_valid (rd_valid),
        .data_we  (data_we),
        .wr_index (pc_q[3+INDEX_BITS:4]),
        .wr_word  (cnt),
        .wr_data  (mem_inst_in),
        .tag_we   (tag_we),
        .wr_tag   (pc_q[ADDR_WIDTH-1:4+INDEX_BITS])
    );

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        kill_n       = kill;
        pc_n         = pc_q;
        line_buf_n   = line_buf;
        ready_n      = ready_out;
        inst_valid_n = FALSE;
        inst_n       = inst_out;
        mem_enable_n = mem_enable_out;
        mem_start_n  = FALSE;
        mem_addr_n   = mem_addr_out;

        case (state)
            IDLE: begin
                ready_n      = TRUE;
                mem_enable_n = FALSE;
                if (accept) begin
                    if (hit) begin
                        inst_valid_n = TRUE;
                        inst_n       = rd_data;
                    end else begin
                        pc_n         = fetch_pc_in[ADDR_WIDTH-1:2];
                        cnt_n        = 2'd0;
                        kill_n       = FALSE;
                        state_n      = REQ;
                        ready_n      = FALSE;
                        mem_enable_n = TRUE;
                        mem_start_n  = TRUE;
                        mem_addr_n   = {fetch_pc_in[ADDR_WIDTH-1:4], 4'b0000};
                    end
                end
            end
            REQ: begin
                state_n = WAIT;
                if (clear_in) begin
                    kill_n = TRUE;
                end
            end
            WAIT: begin
                if (clear_in) begin
                    kill_n = TRUE;
                end
                if (mem_end_in) begin
                    // Capture the requested word as it streams past so the
                    // response never depends on an array read-back.
                    if (cnt == pc_q[3:2]) begin
                        line_buf_n = mem_inst_in;
                    end
                    if (cnt == 2'd3) begin
                        state_n      = IDLE;
                        ready_n      = TRUE;
                        mem_enable_n = FALSE;
                        inst_valid_n = !(kill || clear_in);
                        inst_n       = (pc_q[3:2] == 2'd3) ? mem_inst_in : line_buf;
                    end else begin
                        cnt_n       = cnt + 2'd1;
                        state_n     = REQ;
                        mem_start_n = TRUE;
                        mem_addr_n  = {pc_q[ADDR_WIDTH-1:4], cnt_n, 2'b00};
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state          <= IDLE;
            cnt            <= 2'd0;
            kill           <= FALSE;
            pc_q           <= '0;
            line_buf       <= '0;
            ready_out      <= TRUE;
            inst_valid_out <= FALSE;
            inst_out       <= '0;
            mem_enable_out <= FALSE;
            mem_addr_out   <= '0;
            mem_start_out  <= FALSE;
        end else if (rdy_in) begin
            state          <= state_n;
            cnt            <= cnt_n;
            kill           <= kill_n;
            pc_q           <= pc_n;
            line_buf       <= line_buf_n;
            ready_out      <= ready_n;
            inst_valid_out <= inst_valid_n;
            inst_out       <= inst_n;
            mem_enable_out <= mem_enable_n;
            mem_addr_out   <= mem_addr_n;
            mem_start_out  <= mem_start_n;
        end
    end

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - scoreboard testbench for icache with a variable-latency memory model
module tb_icache;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_pc = 32'h0;
    logic        clear = 1'b0;
    logic        ready, inst_valid, mem_enable, mem_start;
    logic [31:0] inst, mem_addr;
    logic        mem_end = 1'b0;
    logic [31:0] mem_inst = 32'h0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] data;
        int          edge_no;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] addr_q[$];

    icache #(.INDEX_BITS(6)) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .rdy_in         (rdy),
        .fetch_valid_in (fetch_valid),
        .fetch_pc_in    (fetch_pc),
        .clear_in       (clear),
        .ready_out      (ready),
        .inst_valid_out (inst_valid),
        .inst_out       (inst),
        .mem_enable_out (mem_enable),
        .mem_addr_out   (mem_addr),
        .mem_start_out  (mem_start),
        .mem_end_in     (mem_end),
        .mem_inst_in    (mem_inst)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Memory controller model: 3-cycle word latency after each start pulse,
    // frozen while rdy is low, data = address ^ A5A5A5A5.
    initial begin
        int          cnt;
        logic        r, s, ps;
        logic [31:0] a, cur_a;
        cnt = 0;
        ps = 1'b0;
        cur_a = 32'h0;
        forever begin
            @(posedge clk);
            r = rdy;
            s = mem_start;
            a = mem_addr;
            #1;
            if (rst) begin
                mem_end = 1'b0;
                cnt = 0;
                ps = 1'b0;
            end else if (r) begin
                mem_end = 1'b0;
                if (s) begin
                    if (addr_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_read: got addr %h expected no read", a);
                    end else begin
                        check("read_addr", {ps, a}, {1'b0, addr_q.pop_front()});
                    end
                    cur_a = a;
                    cnt = 2;
                end else if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        mem_end = 1'b1;
                        mem_inst = cur_a ^ 32'hA5A5A5A5;
                    end
                end
                ps = s;
            end
        end
    end

    // Response monitor: pops the scoreboard on every inst_valid pulse.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst && inst_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_inst: got %h at edge %0d expected no response", inst, cyc);
            end else begin
                e = exp_q.pop_front();
                check("inst_data", inst, e.data);
                check("inst_edge", cyc, e.edge_no);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request for one cycle; lat < 0 means no response expected.
    task automatic fetch(input logic [31:0] pc, input logic miss, input logic [31:0] data, input int lat);
        exp_t e;
        fetch_valid = 1'b1;
        fetch_pc = pc;
        if (miss) begin
            for (int w = 0; w < 4; w++) begin
                addr_q.push_back({pc[31:4], w[1:0], 2'b00});
            end
        end
        if (lat >= 0) begin
            e.data = data;
            e.edge_no = cyc + 1 + lat;
            exp_q.push_back(e);
        end
        step();
        fetch_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || addr_q.size() != 0 || !ready) && n < 300) begin
            step();
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL %s: got timeout after %0d cycles expected idle", name, n);
        end
        step();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [95:0] snap;

        // Reset values
        step();
        step();
        check("rst_ready", ready, 1'b1);
        check("rst_inst_valid", inst_valid, 1'b0);
        check("rst_inst", inst, 32'h0);
        check("rst_mem_enable", mem_enable, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_start", mem_start, 1'b0);
        rst = 1'b0;
        step();

        // Cold miss on 0x104
        fetch(32'h0000_0104, 1'b1, 32'hA5A5_A4A1, 16);
        check("miss_ready_low", ready, 1'b0);
        wait_idle("cold_miss");

        // Back-to-back hits on the filled line
        fetch(32'h0000_0100, 1'b0, 32'hA5A5_A4A5, 0);
        check("hit0_no_mem", mem_enable, 1'b0);
        fetch(32'h0000_0108, 1'b0, 32'hA5A5_A4AD, 0);
        check("hit1_no_mem", mem_enable, 1'b0);
        fetch(32'h0000_010C, 1'b0, 32'hA5A5_A4A9, 0);
        check("hit2_no_mem", mem_enable, 1'b0);
        wait_idle("hits");

        // Conflict eviction: 0x500 shares index with 0x100
        fetch(32'h0000_0500, 1'b1, 32'hA5A5_A0A5, 16);
        wait_idle("evict_fill");
        fetch(32'h0000_0100, 1'b1, 32'hA5A5_A4A5, 16);
        wait_idle("evict_refetch");

        // Clear during the second WAIT of a miss on 0x200
        fetch(32'h0000_0200, 1'b1, 32'h0, -1);
        repeat (5) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        wait_idle("clear_refill");
        repeat (3) step();
        fetch(32'h0000_0204, 1'b0, 32'hA5A5_A7A1, 0);
        wait_idle("clear_hit");

        // Clear in IDLE discards a same-cycle hit request
        fetch_valid = 1'b1;
        fetch_pc = 32'h0000_0204;
        clear = 1'b1;
        step();
        fetch_valid = 1'b0;
        clear = 1'b0;
        step();
        step();
        check("idle_clear_ready", ready, 1'b1);

        // rdy low for 5 cycles inside WAIT with mem_end withheld
        fetch(32'h0000_0300, 1'b1, 32'hA5A5_A6A5, 21);
        step();
        snap = {ready, inst_valid, inst, mem_enable, mem_addr, mem_start};
        check("freeze_wait_addr", {mem_enable, mem_start, mem_addr}, {1'b1, 1'b0, 32'h0000_0300});
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("freeze_outputs", {ready, inst_valid, inst, mem_enable, mem_addr, mem_start}, snap);
            check("freeze_no_end", mem_end, 1'b0);
        end
        rdy = 1'b1;
        wait_idle("freeze_refill");

        // Asynchronous reset during REQ
        fetch(32'h0000_0400, 1'b0, 32'h0, -1);
        check("req_start", {mem_enable, mem_start, mem_addr}, {1'b1, 1'b1, 32'h0000_0400});
        rst = 1'b1;
        #1;
        check("async_rst_outputs", {ready, inst_valid, inst, mem_enable, mem_addr, mem_start},
              {1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0});
        step();
        step();
        rst = 1'b0;
        step();
        fetch(32'h0000_0100, 1'b1, 32'hA5A5_A4A5, 16);
        wait_idle("post_rst_miss");

        check("scoreboard_empty", exp_q.size(), 0);
        check("reads_empty", addr_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
